// File: rtl/led_request_scheduler.sv
// ============================================================================
// Module      : led_request_scheduler
// Description : Round-robin sharing of a 3-bit LED bank between NREQ
//               requesters; each grant shows a pattern for N prescaler ticks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_request_scheduler #(
  parameter int T         = 1000000,
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int GAP_TICKS = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [3*NREQ-1:0] req_pattern,
  input  logic [DW*NREQ-1:0] req_ticks,
  output logic [NREQ-1:0]   req_ready,
  output logic [2:0]        led,
  output logic              busy,
  output logic [1:0]        grant_id
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SHOW = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [31:0] c_presc_last = 32'(T);
  localparam logic [31:0] c_gap_last   = (GAP_TICKS > 0) ? 32'(GAP_TICKS - 1) : 32'd0;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [31:0]     r_presc;
  logic [31:0]     r_gap;
  logic [2:0]      r_pattern;
  logic [DW-1:0]   r_rem;
  logic [1:0]      r_grant_id;
  logic [1:0]      r_ptr;

  logic            w_tick;
  logic            w_found;
  logic            w_accept;
  logic [1:0]      w_win;
  logic [1:0]      w_ptr_nxt;
  logic [2:0]      w_slot;
  logic [3:0]      w_valid_pad;
  logic [3:0]      w_ready_pad;
  logic [11:0]     w_pat_pad;
  logic [4*DW-1:0] w_ticks_pad;
  logic [2:0]      w_pat;
  logic [DW-1:0]   w_ticks;

  assign w_tick = (r_presc == c_presc_last);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 32'd1;
    end
  end

  // Request vectors are padded to four lanes so lane indices are always 2 bits.
  assign w_valid_pad = 4'(req_valid);
  assign w_pat_pad   = 12'(req_pattern);
  assign w_ticks_pad = (4*DW)'(req_ticks);

  always_comb begin
    w_found = 1'b0;
    w_win   = 2'd0;
    w_slot  = 3'd0;
    for (int k = 0; k < NREQ; k++) begin
      w_slot = {1'b0, r_ptr} + 3'(k);
      if (w_slot >= 3'(NREQ)) begin
        w_slot = w_slot - 3'(NREQ);
      end
      if (!w_found && w_valid_pad[w_slot[1:0]]) begin
        w_found = 1'b1;
        w_win   = w_slot[1:0];
      end
    end
  end

  assign w_accept  = resetn && (r_state == S_IDLE) && w_found;
  assign w_pat     = w_pat_pad[3*w_win +: 3];
  assign w_ticks   = w_ticks_pad[DW*w_win +: DW];
  assign w_ptr_nxt = (w_win == 2'(NREQ - 1)) ? 2'd0 : w_win + 2'd1;

  always_comb begin
    w_ready_pad = 4'b0000;
    if (w_accept) begin
      w_ready_pad[w_win] = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_SHOW;
      S_SHOW: if (w_tick && r_rem == DW'(1)) w_state_nxt = (GAP_TICKS > 0) ? S_GAP : S_IDLE;
      S_GAP:  if (w_tick && r_gap == c_gap_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_gap      <= '0;
      r_pattern  <= '0;
      r_rem      <= '0;
      r_grant_id <= '0;
      r_ptr      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_pattern  <= w_pat;
        r_rem      <= (w_ticks == '0) ? DW'(1) : w_ticks;
        r_grant_id <= w_win;
        r_ptr      <= w_ptr_nxt;
      end
      // Gap counter is cleared throughout SHOW so every gap starts from zero.
      if (r_state == S_SHOW) begin
        r_gap <= '0;
        if (w_tick) begin
          r_rem <= r_rem - DW'(1);
        end
      end
      if (r_state == S_GAP && w_tick) begin
        r_gap <= r_gap + 32'd1;
      end
    end
  end

  assign req_ready = w_ready_pad[NREQ-1:0];
  assign led       = (r_state == S_SHOW) ? r_pattern : 3'b000;
  assign busy      = (r_state != S_IDLE);
  assign grant_id  = r_grant_id;

endmodule

`default_nettype wire

// File: tb/tb_led_request_scheduler.sv
// ============================================================================
// Module      : tb_led_request_scheduler
// Description : Directed, table-driven bench for led_request_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_request_scheduler;

  logic        clk;
  logic        resetn;
  logic [3:0]  req_valid;
  logic [11:0] req_pattern;
  logic [31:0] req_ticks;
  logic [3:0]  req_ready;
  logic [2:0]  led;
  logic        busy;
  logic [1:0]  grant_id;

  logic [3:0]  v0;
  logic [11:0] p0;
  logic [31:0] t0;
  logic [3:0]  ready0;
  logic [2:0]  led0;
  logic        busy0;
  logic [1:0]  gid0;

  int total = 0;
  int bad   = 0;
  int m_presc;
  logic m_tick;

  led_request_scheduler #(.T(3), .NREQ(4), .DW(8), .GAP_TICKS(1)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_pattern(req_pattern),
    .req_ticks(req_ticks), .req_ready(req_ready), .led(led), .busy(busy), .grant_id(grant_id)
  );

  led_request_scheduler #(.T(3), .NREQ(4), .DW(8), .GAP_TICKS(0)) dut0 (
    .clk(clk), .resetn(resetn), .req_valid(v0), .req_pattern(p0),
    .req_ticks(t0), .req_ready(ready0), .led(led0), .busy(busy0), .grant_id(gid0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference prescaler: tick on the cycle the count reaches T=3.
  always @(posedge clk) begin
    if (!resetn) m_presc <= 0;
    else         m_presc <= (m_presc == 3) ? 0 : m_presc + 1;
  end
  assign m_tick = (m_presc == 3);

  typedef struct {
    logic [3:0] valid;
    logic [2:0] pat;
    logic [7:0] ticks;
    logic [3:0] exp_ready;
    logic [1:0] exp_gid;
    int         exp_show;
  } rec_t;

  rec_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] v, input logic [2:0] pat, input logic [7:0] tk);
    req_valid = v;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) begin
        req_pattern[3*i +: 3] = pat;
        req_ticks[8*i +: 8]   = tk;
      end else begin
        req_pattern[3*i +: 3] = ~pat;
        req_ticks[8*i +: 8]   = tk + 8'd3;
      end
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    next();
    next();
    resetn = 1'b1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    req_valid = 4'b0000;
    #1;
    while (busy === 1'b1 && n < 200) begin
      next();
      #1;
      n++;
    end
    chk("wait_idle_timeout", 32'(n < 200), 32'd1);
  endtask

  // Entered mid-cycle while the DUT is idle; returns at the first idle cycle.
  task automatic do_req(input rec_t r);
    int show, gap, n;
    set_req(r.valid, r.pat, r.ticks);
    #1;
    chk("req_ready", 32'(req_ready), 32'(r.exp_ready));
    chk("idle_led", 32'(led), 32'd0);
    next();
    req_valid = 4'b0000;
    #1;
    chk("grant_led", 32'(led), 32'(r.pat));
    chk("grant_busy", 32'(busy), 32'd1);
    chk("grant_id", 32'(grant_id), 32'(r.exp_gid));
    show = 0; gap = 0; n = 0;
    while (busy === 1'b1 && n < 200) begin
      if (led == r.pat && m_tick) show++;
      else if (led == 3'b000 && m_tick) gap++;
      next();
      #1;
      n++;
    end
    chk("show_ticks", 32'(show), 32'(r.exp_show));
    chk("gap_ticks", 32'(gap), 32'd1);
    chk("show_timeout", 32'(n < 200), 32'd1);
  endtask

  initial begin
    int g, n, run, seen, checks;
    int e[5];
    logic [3:0] prev_ready;
    logic gid_due, found;

    tbl[0] = '{4'b0001, 3'b101, 8'd2, 4'b0001, 2'd0, 2};
    tbl[1] = '{4'b0100, 3'b011, 8'd0, 4'b0100, 2'd2, 1};
    tbl[2] = '{4'b1000, 3'b111, 8'd3, 4'b1000, 2'd3, 3};
    tbl[3] = '{4'b0010, 3'b001, 8'd1, 4'b0010, 2'd1, 1};
    tbl[4] = '{4'b0001, 3'b110, 8'd1, 4'b0001, 2'd0, 1};
    e = '{0, 1, 2, 3, 0};

    resetn = 1'b0;
    req_valid = '0; req_pattern = '0; req_ticks = '0;
    v0 = '0; p0 = '0; t0 = '0;
    next();
    do_reset();
    #1;
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);

    for (int i = 0; i < 5; i++) do_req(tbl[i]);

    // Round-robin with every requester pending.
    do_reset();
    set_req(4'b1111, 3'b010, 8'd1);
    g = 0; n = 0; prev_ready = 4'b0000; gid_due = 1'b0;
    while (g < 5 && n < 400) begin
      #1;
      if (gid_due) begin
        chk("rr_gid", 32'(grant_id), 32'(e[g-1]));
        gid_due = 1'b0;
      end
      if (req_ready != 4'b0000) begin
        chk("rr_onehot", 32'($onehot(req_ready)), 32'd1);
        chk("rr_order", 32'(req_ready), 32'd1 << e[g]);
        chk("rr_pulse", 32'(prev_ready), 32'd0);
        g++;
        gid_due = 1'b1;
      end
      prev_ready = req_ready;
      next();
      n++;
    end
    chk("rr_grants", 32'(g), 32'd5);
    wait_idle();

    // Reset during SHOW: pointer restarts at 0, so 1010 must pick requester 1.
    do_reset();
    set_req(4'b0100, 3'b110, 8'd5);
    next();
    req_valid = 4'b0000;
    next();
    next();
    #1;
    chk("mid_show_busy", 32'(busy), 32'd1);
    set_req(4'b1010, 3'b011, 8'd1);
    resetn = 1'b0;
    next();
    resetn = 1'b1;
    #1;
    chk("rst_show_led", 32'(led), 32'd0);
    chk("rst_show_busy", 32'(busy), 32'd0);
    chk("rst_show_gid", 32'(grant_id), 32'd0);
    chk("rst_show_ready", 32'(req_ready), 32'b0010);
    next();
    #1;
    chk("rst_show_regrant", 32'(grant_id), 32'd1);
    chk("rst_show_regled", 32'(led), 32'b011);
    wait_idle();

    // Requester 3 raises valid in the tick cycle that ends GAP.
    set_req(4'b0001, 3'b100, 8'd1);
    next();
    req_valid = 4'b0000;
    found = 1'b0; n = 0;
    while (!found && n < 200) begin
      if (busy && led == 3'b000 && m_tick) begin
        found = 1'b1;
        set_req(4'b1000, 3'b100, 8'd1);
        #1;
        chk("gap_end_ready", 32'(req_ready), 32'd0);
        next();
        #1;
        chk("after_gap_ready", 32'(req_ready), 32'b1000);
        chk("after_gap_led", 32'(led), 32'd0);
        chk("after_gap_busy", 32'(busy), 32'd0);
      end else begin
        next();
        n++;
      end
    end
    chk("gap_end_seen", 32'(found), 32'd1);
    next();
    wait_idle();

    // GAP_TICKS=0 build with continuous requests: one blank idle cycle between shows.
    v0 = 4'b0011;
    p0 = {3'b000, 3'b000, 3'b010, 3'b001};
    t0 = {8'd0, 8'd0, 8'd1, 8'd1};
    seen = 0; run = 0; checks = 0; n = 0;
    while (checks < 3 && n < 400) begin
      #1;
      if (led0 != 3'b000) begin
        if (seen != 0 && run > 0) begin
          chk("gap0_idle_cycles", 32'(run), 32'd1);
          checks++;
        end
        seen = 1;
        run = 0;
      end else if (seen != 0) begin
        chk("gap0_busy", 32'(busy0), 32'd0);
        run++;
      end
      next();
      n++;
    end
    chk("gap0_done", 32'(checks), 32'd3);
    v0 = 4'b0000;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
